quad_bcd_counter: RTL and testbench
===================================

Name: quad_bcd_counter

Overview:
- Upstream stage of the 4-digit 7-segment display path.
- Takes raw quadrature encoder inputs A/B, synchronises and glitch-filters them, and decodes direction in X4 mode.
- Scales edges to detents and maintains a 4-digit packed-BCD up/down count (0000-9999).
- The count feeds the display scan/segment-decode stage directly.

Parameters:
- FILTER_CYCLES, 8: consecutive stable cycles required before a synchronised input is accepted (legal range 1-255).
- STEPS_PER_COUNT, 4: valid quadrature edges per BCD increment/decrement (legal range 1-15).

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  synchronous reset, active-high
- i_enc_a  input  1  encoder channel A, asynchronous
- i_enc_b  input  1  encoder channel B, asynchronous
- i_clear  input  1  synchronous count clear, level, sampled each cycle
- o_bcd  output  16  packed BCD: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units
- o_step  output  1  one-cycle pulse, coincident with each o_bcd change caused by a step
- o_dir  output  1  direction of last accepted edge: 1 = up (CW), 0 = down
- o_error  output  1  one-cycle pulse on illegal transition (both channels changed)

Behaviour:
- Reset (i_rst=1 at a clock edge) sets:
  - o_bcd=16'h0000, o_step=0, o_dir=1, o_error=0
  - synchroniser flops=0, filter counters=0, filtered A/B=0, sub-count=0
  - decoder state=INIT
- Synchroniser: 2 flops per channel; no logic between them.
- Filter, per channel:
  - Stable counter increments while the synchronised value differs from the filtered value.
  - It resets to 0 when the synchronised value equals the filtered value or changes.
  - When the counter reaches FILTER_CYCLES, the filtered value takes the synchronised value and the counter clears.
  - Pulses shorter than FILTER_CYCLES cycles are rejected.
- Filter qualify flag: asserted once after reset when both channels have been stable for FILTER_CYCLES cycles, whether or not they differed.
- Decoder FSM:
  - INIT: wait for the qualify flag; latch prev={A,B} filtered, no count, no error; go to TRACK.
  - TRACK, each cycle compare cur={A,B} filtered with prev:
    - Equal: no action.
    - Up sequence 00->01->11->10->00: edge=+1, o_dir=1.
    - Reverse sequence: edge=-1, o_dir=0.
    - Both bits differ: o_error=1 for one cycle, no edge, o_dir unchanged.
    - prev is updated to cur in every case.
  - Decode result is registered (1 cycle).
- Sub-counter, signed, range -(STEPS_PER_COUNT-1)..+(STEPS_PER_COUNT-1):
  - +1 edge at +(S-1): sub-count goes to 0 and an up-step is issued.
  - -1 edge at -(S-1): sub-count goes to 0 and a down-step is issued.
  - Otherwise add the edge.
  - Direction reversal simply moves back toward 0 (hysteresis inherent).
- BCD counter, updated the cycle after the step is issued; o_step asserted the same cycle o_bcd changes:
  - Up: units 9 -> 0 with carry into tens, and so on; 9999 -> 0000 wraps.
  - Down: units 0 -> 9 with borrow; 0000 -> 9999 wraps.
  - Every nibble is always in 0-9.
- Latency, STEPS_PER_COUNT=1, measured from the first i_clk edge sampling a new stable input level to o_bcd/o_step: 2 (sync) + FILTER_CYCLES (filter) + 1 (decode) + 1 (BCD) cycles.
- i_clear:
  - Sets o_bcd=0000 and sub-count=0, and suppresses o_step that cycle.
  - Has priority over a coincident step; that step is lost.
  - Does not affect synchroniser, filter, prev, or FSM state.
- Priority order: i_rst > i_clear > step.
- Reset mid-operation: any pending edge/step is discarded; the FSM returns to INIT, so the first post-reset encoder position never counts.
- o_step and o_error are never asserted in the same cycle. An error cycle produces no edge, so no step follows it.

Test Plan:
- Reset, encoder held at A=1,B=1 with FILTER_CYCLES=4, STEPS_PER_COUNT=4 -> o_bcd stays 0000, o_error never pulses, FSM reaches TRACK after 2+4 cycles.
- From 00, apply 8 up edges (00,01,11,10,00,...) each held 10 cycles -> two o_step pulses, o_bcd 0000->0001->0002, o_dir=1; first pulse exactly 2+4+1+1 cycles after the 4th edge is first sampled.
- At o_bcd=0000, apply 4 down edges -> o_bcd=9999, o_dir=0, one o_step. Preload 0099 via 396 up edges, then 4 up edges -> 0100.
- 3-cycle glitch on A (FILTER_CYCLES=4) -> no filtered change, o_bcd unchanged, no o_error. 4-cycle pulse -> accepted as one edge.
- Filtered 00 -> 11 (both channels switched in the same cycle, held 10 cycles) -> one o_error pulse, no o_step, sub-count unchanged. A subsequent legal 11->10 edge counts down normally.
- i_clear asserted in the same cycle a step would update o_bcd=0005 -> o_bcd=0000, o_step=0. Assert i_rst mid-sequence (sub-count=+2) -> all outputs at reset values next cycle, and the next 3 up edges produce no step.

Source files
------------

// File: rtl/quad_bcd_counter.sv
`timescale 1ns/1ps
// Quadrature encoder front end: two-flop synchroniser, per-channel glitch filter,
// X4 direction decode, detent scaling and a 4-digit packed-BCD up/down count.
module quad_bcd_counter #(
  parameter int FILTER_CYCLES   = 8,
  parameter int STEPS_PER_COUNT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enc_a,
  input  logic        i_enc_b,
  input  logic        i_clear,
  output logic [15:0] o_bcd,
  output logic        o_step,
  output logic        o_dir,
  output logic        o_error
);

  localparam logic [7:0]        FILT_LAST = 8'(FILTER_CYCLES - 1);
  localparam logic signed [4:0] SUB_MAX   = 5'(STEPS_PER_COUNT - 1);
  localparam logic signed [4:0] SUB_MIN   = -SUB_MAX;

  typedef enum logic {S_INIT, S_TRACK} state_t;

  // Bit 1 carries channel A and bit 0 channel B in every 2-bit vector below.
  logic [1:0] meta_q, sync_q, filt_q, filt_d;
  logic [7:0] qual_cnt_q;
  logic       qual_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_q <= '0;
      sync_q <= '0;
      filt_q <= '0;
    end else begin
      meta_q <= {i_enc_a, i_enc_b};
      sync_q <= meta_q;
      filt_q <= filt_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_filt
      logic [7:0] cnt_q, cnt_d;
      logic       differ, accept;
      assign differ     = sync_q[gi] != filt_q[gi];
      assign accept     = differ && (cnt_q == FILT_LAST);
      assign cnt_d      = (differ && !accept) ? cnt_q + 8'd1 : 8'd0;
      assign filt_d[gi] = accept ? sync_q[gi] : filt_q[gi];
      always_ff @(posedge i_clk) begin
        if (i_rst) cnt_q <= '0;
        else       cnt_q <= cnt_d;
      end
    end
  endgenerate

  // Qualify lands on the same edge a filter accepts a settled level, so INIT never latches a stale position.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      qual_cnt_q <= '0;
      qual_q     <= 1'b0;
    end else if (meta_q != sync_q) begin
      qual_cnt_q <= '0;
    end else if (!qual_q) begin
      if (qual_cnt_q == FILT_LAST) qual_q <= 1'b1;
      else                         qual_cnt_q <= qual_cnt_q + 8'd1;
    end
  end

  state_t     state_q, state_d;
  logic [1:0] prev_q, prev_d;
  logic       up_q, up_d, dn_q, dn_d, err_q, err_d, dir_q, dir_d;

  function automatic logic [1:0] phase(input logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    err_d   = 1'b0;
    dir_d   = dir_q;
    case (state_q)
      S_INIT: begin
        if (qual_q) begin
          prev_d  = filt_q;
          state_d = S_TRACK;
        end
      end
      S_TRACK: begin
        prev_d = filt_q;
        if ((filt_q ^ prev_q) == 2'b11) begin
          err_d = 1'b1;
        end else if (phase(filt_q) == phase(prev_q) + 2'd1) begin
          up_d  = 1'b1;
          dir_d = 1'b1;
        end else if (filt_q != prev_q) begin
          dn_d  = 1'b1;
          dir_d = 1'b0;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_INIT;
      prev_q  <= '0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      err_q   <= 1'b0;
      dir_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      err_q   <= err_d;
      dir_q   <= dir_d;
    end
  end

  logic signed [4:0] sub_q, sub_d;
  logic [15:0]       bcd_q, bcd_d, bcd_inc, bcd_dec;
  logic              step_q, step_d, step_up, step_dn, carry, borrow;

  assign step_up = up_q && (sub_q == SUB_MAX);
  assign step_dn = dn_q && (sub_q == SUB_MIN);

  always_comb begin
    bcd_inc = bcd_q;
    bcd_dec = bcd_q;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (bcd_q[4*i +: 4] == 4'd9) bcd_inc[4*i +: 4] = 4'd0;
        else begin
          bcd_inc[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
      if (borrow) begin
        if (bcd_q[4*i +: 4] == 4'd0) bcd_dec[4*i +: 4] = 4'd9;
        else begin
          bcd_dec[4*i +: 4] = bcd_q[4*i +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  always_comb begin
    sub_d  = sub_q;
    bcd_d  = bcd_q;
    step_d = 1'b0;
    if (i_clear) begin
      sub_d = '0;
      bcd_d = '0;
    end else if (step_up) begin
      sub_d  = '0;
      bcd_d  = bcd_inc;
      step_d = 1'b1;
    end else if (step_dn) begin
      sub_d  = '0;
      bcd_d  = bcd_dec;
      step_d = 1'b1;
    end else if (up_q) begin
      sub_d = sub_q + 5'sd1;
    end else if (dn_q) begin
      sub_d = sub_q - 5'sd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sub_q  <= '0;
      bcd_q  <= '0;
      step_q <= 1'b0;
    end else begin
      sub_q  <= sub_d;
      bcd_q  <= bcd_d;
      step_q <= step_d;
    end
  end

  assign o_bcd   = bcd_q;
  assign o_step  = step_q;
  assign o_dir   = dir_q;
  assign o_error = err_q;

endmodule

// File: tb/tb_quad_bcd_counter.sv
`timescale 1ns/1ps
// Bench for quad_bcd_counter: scripted scenarios plus a random walk, checked against
// a model that tracks encoder position, detent remainder and an integer count.
module tb_quad_bcd_counter;
  localparam int F   = 4;
  localparam int S   = 4;
  localparam int LAT = 2 + F + 1 + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enc_a = 1'b0;
  logic        enc_b = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] o_bcd;
  logic        o_step, o_dir, o_error;

  always #5 clk = ~clk;

  quad_bcd_counter #(.FILTER_CYCLES(F), .STEPS_PER_COUNT(S)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_enc_a (enc_a),
    .i_enc_b (enc_b),
    .i_clear (clear),
    .o_bcd   (o_bcd),
    .o_step  (o_step),
    .o_dir   (o_dir),
    .o_error (o_error)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_cnt = 0;
  int   err_cnt  = 0;
  int   both_cnt = 0;
  int   m_pos    = 0;
  int   m_sub    = 0;
  int   m_count  = 0;
  logic m_dir    = 1'b1;

  always @(negedge clk) begin
    if (!rst) begin
      if (o_step === 1'b1) step_cnt++;
      if (o_error === 1'b1) err_cnt++;
      if (o_step === 1'b1 && o_error === 1'b1) both_cnt++;
    end
  end

  function automatic logic [1:0] enc_code(input int p);
    case (p)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic drive_pos(input int p);
    m_pos = p;
    {enc_a, enc_b} = enc_code(p);
  endtask

  task automatic do_reset(input int p);
    rst   = 1'b1;
    clear = 1'b0;
    drive_pos(p);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    m_sub   = 0;
    m_count = 0;
    m_dir   = 1'b1;
  endtask

  // One legal detent-quarter move, checked for step timing, count and direction.
  task automatic move(input int dir, input int hold);
    int   lat;
    int   exp_lat;
    logic exp_step;
    drive_pos((m_pos + dir + 4) % 4);
    m_sub    = m_sub + dir;
    m_dir    = (dir > 0);
    exp_step = 1'b0;
    if (m_sub == S) begin
      m_sub = 0; m_count = (m_count + 1) % 10000; exp_step = 1'b1;
    end else if (m_sub == -S) begin
      m_sub = 0; m_count = (m_count + 9999) % 10000; exp_step = 1'b1;
    end
    lat = 0;
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      if (o_step === 1'b1 && lat == 0) lat = i;
    end
    exp_lat = exp_step ? LAT : 0;
    n_checks++;
    if (lat != exp_lat) begin
      n_fail++;
      $display("FAIL move_step_latency: got %0d required %0d (pos %0d)", lat, exp_lat, m_pos);
    end
    n_checks++;
    if (o_bcd !== to_bcd(m_count)) begin
      n_fail++;
      $display("FAIL move_bcd: got %h required %h", o_bcd, to_bcd(m_count));
    end
    n_checks++;
    if (o_dir !== m_dir) begin
      n_fail++;
      $display("FAIL move_dir: got %b required %b", o_dir, m_dir);
    end
  endtask

  task automatic test_reset;
    int bs, be;
    rst = 1'b1;
    drive_pos(2);
    repeat (2) @(negedge clk);
    n_checks++;
    if (o_bcd !== 16'h0000) begin n_fail++; $display("FAIL reset_bcd: got %h required 0000", o_bcd); end
    n_checks++;
    if (o_step !== 1'b0) begin n_fail++; $display("FAIL reset_step: got %b required 0", o_step); end
    n_checks++;
    if (o_dir !== 1'b1) begin n_fail++; $display("FAIL reset_dir: got %b required 1", o_dir); end
    n_checks++;
    if (o_error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b required 0", o_error); end
    bs = step_cnt; be = err_cnt;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++;
    if (err_cnt != be) begin n_fail++; $display("FAIL reset_held11_error: got %0d pulses required 0", err_cnt - be); end
    n_checks++;
    if (step_cnt != bs || o_bcd !== 16'h0000) begin
      n_fail++; $display("FAIL reset_held11_count: got %h/%0d steps required 0000/0", o_bcd, step_cnt - bs);
    end
    m_sub = 0; m_count = 0; m_dir = 1'b1;
    move(1, 10);
  endtask

  task automatic test_up_count;
    int bs;
    do_reset(0);
    bs = step_cnt;
    repeat (8) move(1, 10);
    n_checks++;
    if (step_cnt - bs != 2) begin n_fail++; $display("FAIL up_step_pulses: got %0d required 2", step_cnt - bs); end
  endtask

  task automatic test_down_wrap;
    do_reset(0);
    repeat (4) move(-1, 10);
    repeat (4) move(1, 10);
  endtask

  task automatic test_carry;
    do_reset(0);
    repeat (396) move(1, 8);
    repeat (4) move(1, 10);
  endtask

  task automatic test_glitch;
    int bs, be;
    do_reset(0);
    repeat (3) move(1, 10);
    bs = step_cnt; be = err_cnt;
    enc_a = 1'b0;
    repeat (F - 1) @(negedge clk);
    enc_a = 1'b1;
    repeat (14) @(negedge clk);
    n_checks++;
    if (step_cnt != bs || err_cnt != be || o_bcd !== to_bcd(m_count) || o_dir !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_short: got bcd %h dir %b steps %0d errs %0d required bcd %h dir 1 steps 0 errs 0",
               o_bcd, o_dir, step_cnt - bs, err_cnt - be, to_bcd(m_count));
    end
    enc_a = 1'b0;
    repeat (F) @(negedge clk);
    enc_a = 1'b1;
    repeat (16) @(negedge clk);
    m_count = (m_count + 1) % 10000;
    m_sub   = -1;
    m_dir   = 1'b0;
    n_checks++;
    if (step_cnt - bs != 1 || err_cnt != be) begin
      n_fail++; $display("FAIL glitch_accept_pulses: got steps %0d errs %0d required 1 and 0", step_cnt - bs, err_cnt - be);
    end
    n_checks++;
    if (o_bcd !== to_bcd(m_count) || o_dir !== m_dir) begin
      n_fail++; $display("FAIL glitch_accept_state: got %h dir %b required %h dir %b", o_bcd, o_dir, to_bcd(m_count), m_dir);
    end
    move(-1, 10);
  endtask

  task automatic test_illegal;
    int bs, be;
    do_reset(0);
    repeat (3) move(1, 10);
    bs = step_cnt; be = err_cnt;
    drive_pos(1);
    repeat (12) @(negedge clk);
    n_checks++;
    if (err_cnt - be != 1) begin n_fail++; $display("FAIL illegal_error_pulses: got %0d required 1", err_cnt - be); end
    n_checks++;
    if (step_cnt != bs || o_bcd !== to_bcd(m_count) || o_dir !== 1'b1) begin
      n_fail++; $display("FAIL illegal_no_step: got %h dir %b steps %0d required %h dir 1 steps 0",
                         o_bcd, o_dir, step_cnt - bs, to_bcd(m_count));
    end
    move(1, 10);
    move(-1, 10);
    move(-1, 10);
  endtask

  task automatic test_clear;
    int bs;
    do_reset(0);
    repeat (20) move(1, 8);
    repeat (3) move(1, 8);
    drive_pos((m_pos + 1) % 4);
    bs = step_cnt;
    repeat (LAT - 1) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    n_checks++;
    if (o_bcd !== 16'h0000 || o_step !== 1'b0) begin
      n_fail++; $display("FAIL clear_vs_step: got bcd %h step %b required 0000 step 0", o_bcd, o_step);
    end
    clear = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (step_cnt != bs || o_bcd !== 16'h0000) begin
      n_fail++; $display("FAIL clear_step_lost: got bcd %h steps %0d required 0000 steps 0", o_bcd, step_cnt - bs);
    end
    m_count = 0; m_sub = 0;
    repeat (4) move(1, 10);
  endtask

  task automatic test_reset_mid;
    int bs, be;
    do_reset(0);
    repeat (6) move(1, 10);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (o_bcd !== 16'h0000 || o_step !== 1'b0 || o_dir !== 1'b1 || o_error !== 1'b0) begin
      n_fail++; $display("FAIL midreset_outputs: got bcd %h step %b dir %b err %b required 0000 0 1 0",
                         o_bcd, o_step, o_dir, o_error);
    end
    rst = 1'b0;
    bs = step_cnt; be = err_cnt;
    repeat (15) @(negedge clk);
    n_checks++;
    if (step_cnt != bs || err_cnt != be) begin
      n_fail++; $display("FAIL midreset_reacquire: got steps %0d errs %0d required 0 and 0", step_cnt - bs, err_cnt - be);
    end
    m_count = 0; m_sub = 0; m_dir = 1'b1;
    repeat (3) move(1, 10);
    move(1, 10);
  endtask

  task automatic test_random;
    int dir;
    do_reset($urandom_range(0, 3));
    for (int i = 0; i < 80; i++) begin
      if (i < 40) dir = ($urandom_range(0, 9) < 7) ? 1 : -1;
      else        dir = ($urandom_range(0, 9) < 7) ? -1 : 1;
      move(dir, $urandom_range(8, 14));
    end
  endtask

  task automatic test_exclusive;
    n_checks++;
    if (both_cnt != 0) begin n_fail++; $display("FAIL step_error_overlap: got %0d cycles required 0", both_cnt); end
  endtask

  initial begin
    test_reset;
    test_up_count;
    test_down_wrap;
    test_carry;
    test_glitch;
    test_illegal;
    test_clear;
    test_reset_mid;
    test_random;
    test_exclusive;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
